// File: rtl/act_row_buffer.sv
// act_row_buffer: requantizes 16 skewed activation lanes into per-lane FIFOs and emits packed 8-bit rows.
// Optional feature macro ACT_ROW_BUFFER_SAT_EN: oversized results saturate to all-ones instead of wrapping.
module act_row_buffer #(
   parameter int LANES = 16,
   parameter int IN_W  = 20,
   parameter int OUT_W = 8,
   parameter int DEPTH = 8,
   parameter int SHIFT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LANES*IN_W-1:0]  act_in,
   input  logic [LANES-1:0]       act_valid,
   input  logic                   ovf_clr,
   output logic [LANES*OUT_W-1:0] row_data,
   output logic                   row_valid,
   input  logic                   row_ready,
   output logic [LANES-1:0]       ovf,
   output logic [15:0]            rows_out
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT - 1);
   logic [PW-1:0] rd_ptr;
   logic [LANES-1:0] nonempty;
   logic [LANES-1:0] drop;
   logic pop;
   assign row_valid = &nonempty;
   assign pop = row_valid && row_ready;
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [IN_W-1:0] x;
      logic signed [IN_W:0] s;
      logic signed [IN_W:0] q;
      logic [OUT_W-1:0] big;
      logic [OUT_W-1:0] qv;
      logic [OUT_W-1:0] mem [DEPTH];
      logic [PW-1:0] wr_ptr;
      logic [CW-1:0] count;
      logic full;
      logic push;
      assign x = act_in[g*IN_W +: IN_W];
      assign s = $signed({x[IN_W-1], x} + RND);
      assign q = s >>> SHIFT;
`ifdef ACT_ROW_BUFFER_SAT_EN
      assign big = {OUT_W{1'b1}};
`else
      assign big = q[OUT_W-1:0];
`endif
      assign qv = x[IN_W-1] ? '0 : (|q[IN_W:OUT_W]) ? big : q[OUT_W-1:0];
      assign full = count == CW'(DEPTH);
      assign push = act_valid[g] && (!full || pop);
      assign drop[g] = act_valid[g] && full && !pop;
      assign nonempty[g] = count != '0;
      assign row_data[g*OUT_W +: OUT_W] = nonempty[g] ? mem[rd_ptr] : '0;
      // lane storage, written only on accepted pushes; contents are never reset
      always_ff @(posedge clk)
         if (push) mem[wr_ptr] <= qv;
      // lane write position and occupancy; a push with a pop leaves the count unchanged
      always_ff @(posedge clk or negedge rst)
         if (!rst) begin
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            wr_ptr <= wr_ptr + PW'(push);
            count  <= count + CW'(push) - CW'(pop);
         end
   end
   // shared read pointer, popped-row counter and sticky overflow flags (a new overflow beats clear)
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rd_ptr   <= '0;
         rows_out <= '0;
         ovf      <= '0;
      end else begin
         rd_ptr   <= rd_ptr + PW'(pop);
         rows_out <= rows_out + 16'(pop);
         ovf      <= (ovf & ~{LANES{ovf_clr}}) | drop;
      end
endmodule

// File: tb/tb_act_row_buffer.sv
// tb_act_row_buffer: scoreboard bench for act_row_buffer; honours ACT_ROW_BUFFER_SAT_EN in its model.
module tb_act_row_buffer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [319:0] act_in = '0;
   logic [15:0] act_valid = '0;
   logic ovf_clr = 1'b0;
   logic [127:0] row_data;
   logic row_valid;
   logic row_ready = 1'b0;
   logic [15:0] ovf;
   logic [15:0] rows_out;
   logic [127:0] exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
`ifdef ACT_ROW_BUFFER_SAT_EN
   localparam logic [7:0] BIG_EXP = 8'hFF;
`else
   localparam logic [7:0] BIG_EXP = 8'h00;
`endif

   act_row_buffer dut (
      .clk(clk), .rst(rst), .act_in(act_in), .act_valid(act_valid), .ovf_clr(ovf_clr),
      .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready), .ovf(ovf), .rows_out(rows_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] quant(input logic [19:0] x);
      int v;
      if (x[19]) return 8'h00;
      v = (int'(x) + 8) / 16;
`ifdef ACT_ROW_BUFFER_SAT_EN
      if (v > 255) return 8'hFF;
`endif
      return v[7:0];
   endfunction

   task automatic drive(input logic [15:0] m);
      act_valid = m;
      @(posedge clk); #1;
      act_valid = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0; row_ready = 1'b0; ovf_clr = 1'b0;
      act_in = {16{20'h00123}}; act_valid = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL reset_row_valid: got %b want 0", row_valid); end
      n_checks++; if (ovf !== 16'h0) begin n_fail++; $display("FAIL reset_ovf: got %h want 0000", ovf); end
      n_checks++; if (rows_out !== 16'h0) begin n_fail++; $display("FAIL reset_rows_out: got %0d want 0", rows_out); end
      n_checks++; if (row_data !== 128'h0) begin n_fail++; $display("FAIL reset_row_data: got %h want 0", row_data); end
      act_valid = '0; rst = 1'b1;
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b want 0", row_valid); end
   endtask

   task automatic test_aligned();
      logic [127:0] e;
      row_ready = 1'b1;
      act_in = {16{20'h00123}};
      exp_q.push_back({16{8'h12}});
      drive('1);
      @(negedge clk);
      n_checks++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL aligned_valid: got %b want 1", row_valid); end
      e = exp_q.pop_front();
      n_checks++; if (row_data !== e) begin n_fail++; $display("FAIL aligned_data: got %h want %h", row_data, e); end
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (rows_out !== 16'd1) begin n_fail++; $display("FAIL aligned_rows_out: got %0d want 1", rows_out); end
      n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL aligned_drop: got %b want 0", row_valid); end
   endtask

   task automatic test_skewed();
      logic [127:0] e;
      for (int i = 0; i < 16; i++) e[i*8 +: 8] = quant(20'(i*16));
      exp_q.push_back(e);
      row_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         act_in[i*20 +: 20] = 20'(i*16);
         drive(16'(1 << i));
         @(negedge clk);
         n_checks++;
         if (row_valid !== (i == 15)) begin n_fail++; $display("FAIL skew_valid_%0d: got %b want %b", i, row_valid, i == 15); end
      end
      e = exp_q.pop_front();
      n_checks++; if (row_data !== e) begin n_fail++; $display("FAIL skew_data: got %h want %h", row_data, e); end
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (rows_out !== 16'd2) begin n_fail++; $display("FAIL skew_rows_out: got %0d want 2", rows_out); end
   endtask

   task automatic test_overflow();
      logic [127:0] e;
      row_ready = 1'b0;
      for (int j = 1; j <= 9; j++) begin
         act_in[3*20 +: 20] = 20'(j*16);
         drive(16'h0008);
         @(negedge clk);
         n_checks++;
         if (ovf !== (j == 9 ? 16'h0008 : 16'h0000)) begin n_fail++; $display("FAIL ovf_write_%0d: got %h want %h", j, ovf, j == 9 ? 16'h0008 : 16'h0000); end
      end
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      @(negedge clk);
      n_checks++; if (ovf !== 16'h0) begin n_fail++; $display("FAIL ovf_clear: got %h want 0000", ovf); end
      act_in = '0;
      for (int i = 0; i < 16; i++) e[i*8 +: 8] = (i == 3) ? quant(20'd16) : quant(20'd0);
      exp_q.push_back(e);
      drive(~16'h0008);
      @(negedge clk);
      n_checks++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_row_valid: got %b want 1", row_valid); end
      e = exp_q.pop_front();
      n_checks++; if (row_data !== e) begin n_fail++; $display("FAIL ovf_row_data: got %h want %h", row_data, e); end
      row_ready = 1'b1;
      act_in[3*20 +: 20] = 20'd160;
      drive(16'h0008);
      row_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (ovf !== 16'h0) begin n_fail++; $display("FAIL ovf_full_pop: got %h want 0000", ovf); end
      n_checks++; if (rows_out !== 16'd3) begin n_fail++; $display("FAIL ovf_rows_out: got %0d want 3", rows_out); end
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 16; i++) begin
            if (i != 3) act_in[i*20 +: 20] = 20'h00123 + 20'(r*16);
            e[i*8 +: 8] = (i == 3) ? quant(r < 7 ? 20'((r+2)*16) : 20'd160) : quant(20'h00123 + 20'(r*16));
         end
         exp_q.push_back(e);
         drive(~16'h0008);
      end
      row_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (row_valid) begin
            e = exp_q.pop_front();
            n_checks++; if (row_data !== e) begin n_fail++; $display("FAIL drain_data_%0d: got %h want %h", c, row_data, e); end
         end
         @(posedge clk); #1;
      end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_timeout: %0d rows left want 0", exp_q.size()); exp_q.delete(); end
      row_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", row_valid); end
      n_checks++; if (rows_out !== 16'd11) begin n_fail++; $display("FAIL drain_rows_out: got %0d want 11", rows_out); end
   endtask

   task automatic test_requant();
      logic [19:0] vals [16];
      logic [127:0] e;
      vals = '{20'h0FFFF, 20'hFFFF0, 20'h00007, 20'h00008, 20'h7FFFF, 20'h80000, 20'h00FF7, 20'h00FF8,
               20'h00000, 20'h00017, 20'h00018, 20'hFFFFF, 20'h01000, 20'h00800, 20'h00FE8, 20'h40000};
      for (int i = 0; i < 16; i++) begin
         act_in[i*20 +: 20] = vals[i];
         e[i*8 +: 8] = quant(vals[i]);
      end
      exp_q.push_back(e);
      row_ready = 1'b1;
      drive('1);
      @(negedge clk);
      n_checks++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL rq_valid: got %b want 1", row_valid); end
      e = exp_q.pop_front();
      n_checks++; if (row_data !== e) begin n_fail++; $display("FAIL rq_row: got %h want %h", row_data, e); end
      n_checks++; if (row_data[7:0] !== BIG_EXP) begin n_fail++; $display("FAIL rq_0ffff: got %h want %h", row_data[7:0], BIG_EXP); end
      n_checks++; if (row_data[15:8] !== 8'h00) begin n_fail++; $display("FAIL rq_ffff0: got %h want 00", row_data[15:8]); end
      n_checks++; if (row_data[23:16] !== 8'h00) begin n_fail++; $display("FAIL rq_00007: got %h want 00", row_data[23:16]); end
      n_checks++; if (row_data[31:24] !== 8'h01) begin n_fail++; $display("FAIL rq_00008: got %h want 01", row_data[31:24]); end
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (rows_out !== 16'd12) begin n_fail++; $display("FAIL rq_rows_out: got %0d want 12", rows_out); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] e;
      row_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         act_in = {16{20'((r+1)*256)}};
         exp_q.push_back({16{8'((r+1)*16)}});
         act_valid = '1;
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d: got %b want 1", r, row_valid); end
         e = exp_q.pop_front();
         n_checks++; if (row_data !== e) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", r, row_data, e); end
      end
      act_valid = '0;
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %b want 0", row_valid); end
      n_checks++; if (rows_out !== 16'd16) begin n_fail++; $display("FAIL b2b_rows_out: got %0d want 16", rows_out); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] e;
      row_ready = 1'b0;
      for (int r = 0; r < 3; r++) begin
         act_in = {16{20'((r+1)*256)}};
         drive('1);
      end
      @(negedge clk);
      n_checks++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered: got %b want 1", row_valid); end
      n_checks++; if (row_data !== {16{8'h10}}) begin n_fail++; $display("FAIL mid_head: got %h want %h", row_data, {16{8'h10}}); end
      rst = 1'b0;
      #1;
      n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", row_valid); end
      n_checks++; if (rows_out !== 16'd0) begin n_fail++; $display("FAIL mid_async_rows: got %0d want 0", rows_out); end
      @(negedge clk);
      rst = 1'b1;
      act_in = {16{20'h00456}};
      exp_q.push_back({16{8'h45}});
      row_ready = 1'b1;
      @(posedge clk); #1;
      drive('1);
      @(negedge clk);
      n_checks++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL mid_new_valid: got %b want 1", row_valid); end
      e = exp_q.pop_front();
      n_checks++; if (row_data !== e) begin n_fail++; $display("FAIL mid_new_data: got %h want %h", row_data, e); end
      @(posedge clk); #1; @(negedge clk);
      n_checks++; if (rows_out !== 16'd1) begin n_fail++; $display("FAIL mid_rows_out: got %0d want 1", rows_out); end
      n_checks++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got %b want 0", row_valid); end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_skewed();
      test_overflow();
      test_requant();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
